mem_port_arbiter: RTL and testbench

//  Two-requester arbiter for the shared memory-address datapath of the multicycle core.

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/arb_lat_counter.sv | 40 ++++
 rtl/mem_port_arbiter.sv | 111 +++++++++++
 tb/tb_mem_port_arbiter.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared state encodings and mux-select codes for the memory-port arbiter.
// Optional feature macro used by this slice: ARB_ROUND_ROBIN_EN.
package mem_arb_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_GRANT0 = 2'd1;
    localparam state_t ST_GRANT1 = 2'd2;

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_0    = 2'b01;
    localparam logic [1:0] SEL_1    = 2'b10;

    // One-hot mux select that corresponds to an arbiter state.
    function automatic logic [1:0] sel_of(input state_t st);
        case (st)
            ST_GRANT0: sel_of = SEL_0;
            ST_GRANT1: sel_of = SEL_1;
            default:   sel_of = SEL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/arb_lat_counter.sv
// Access-latency down-counter: loadable, decrements only while nonzero.
// zero_next gives the flag value after the coming edge so done can be registered.
module arb_lat_counter #(
    parameter int LAT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [LAT_WIDTH-1:0] load_val,
    input  logic                 dec,
    output logic                 zero,
    output logic                 zero_next
);

    logic [LAT_WIDTH-1:0] cnt;
    logic [LAT_WIDTH-1:0] cnt_next;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        cnt_next = cnt;
        if (load) begin
            cnt_next = load_val;
        end else if (dec && (cnt != '0)) begin
            cnt_next = cnt - 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_next;
        end
    end

    assign zero      = (cnt == '0);
    assign zero_next = (cnt_next == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter for the shared memory-address mux, with one idle turnaround between grants.
// Define ARB_ROUND_ROBIN_EN for round-robin on contention; default is fixed priority to port 0.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LATENCY = 3,
    parameter int LAT_WIDTH   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       req1,
    output logic [1:0] sel,
    output logic       mem_en,
    output logic       done0,
    output logic       done1,
    output logic       busy
);

    localparam logic [LAT_WIDTH-1:0] LOAD_VAL = LAT_WIDTH'(MEM_LATENCY - 1);

    state_t     state;
    state_t     state_next;
    logic       pick1;
    logic       cnt_load;
    logic       cnt_dec;
    logic       cnt_zero;
    logic       cnt_zero_next;
    logic [1:0] sel_next;
    logic       mem_en_next;
    logic       done0_next;
    logic       done1_next;
    logic       busy_next;

`ifdef ARB_ROUND_ROBIN_EN
    logic last;

    // On contention the port that was not served last wins.
    assign pick1 = req1 && (!req0 || !last);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last <= 1'b1;
        end else if (cnt_load) begin
            last <= (state_next == ST_GRANT1);
        end
    end
`else
    assign pick1 = req1 && !req0;
`endif

    assign cnt_load = (state == ST_IDLE) && (state_next != ST_IDLE);
    assign cnt_dec  = (state != ST_IDLE);

    arb_lat_counter #(
        .LAT_WIDTH(LAT_WIDTH)
    ) u_lat_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (LOAD_VAL),
        .dec      (cnt_dec),
        .zero     (cnt_zero),
        .zero_next(cnt_zero_next)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            sel    <= SEL_NONE;
            mem_en <= 1'b0;
            done0  <= 1'b0;
            done1  <= 1'b0;
            busy   <= 1'b0;
        end else begin
            state  <= state_next;
            sel    <= sel_next;
            mem_en <= mem_en_next;
            done0  <= done0_next;
            done1  <= done1_next;
            busy   <= busy_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (req0 || req1) begin
                    state_next = pick1 ? ST_GRANT1 : ST_GRANT0;
                end
            end
            ST_GRANT0, ST_GRANT1: begin
                if (cnt_zero) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so that they leave the register aligned with it.
    always_comb begin
        sel_next    = sel_of(state_next);
        mem_en_next = (state_next != ST_IDLE);
        busy_next   = (state_next != ST_IDLE);
        done0_next  = (state_next == ST_GRANT0) && cnt_zero_next;
        done1_next  = (state_next == ST_GRANT1) && cnt_zero_next;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scoreboard bench for mem_port_arbiter (latency 3 and latency 1 instances),
// plus per-cycle protocol invariants under random request streams.
module tb_mem_port_arbiter;

    typedef struct packed {
        logic [1:0] sel;
        logic       mem_en;
        logic       done0;
        logic       done1;
        logic       busy;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0, req1, ra0, ra1;
    logic [1:0] sel, sel_b;
    logic       mem_en, done0, done1, busy;
    logic       mem_en_b, done0_b, done1_b, busy_b;

    int   checks   = 0;
    int   failures = 0;
    obs_t exp_q[$];

    always #5 clk = ~clk;

    mem_port_arbiter #(.MEM_LATENCY(3), .LAT_WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req0  (req0),
        .req1  (req1),
        .sel   (sel),
        .mem_en(mem_en),
        .done0 (done0),
        .done1 (done1),
        .busy  (busy)
    );

    mem_port_arbiter #(.MEM_LATENCY(1), .LAT_WIDTH(4)) dut_l1 (
        .clk   (clk),
        .rst_n (rst_n),
        .req0  (ra0),
        .req1  (ra1),
        .sel   (sel_b),
        .mem_en(mem_en_b),
        .done0 (done0_b),
        .done1 (done1_b),
        .busy  (busy_b)
    );

    // One clock: drive inputs for the current cycle, push the outputs expected in the next cycle,
    // then pop and compare once the edge has produced them.
    task automatic cyc(input bit use_l1, input logic rst, input logic a, input logic b,
                       input logic [1:0] s, input logic d0, input logic d1, input string tag);
        obs_t e;
        obs_t o;
        rst_n = rst;
        if (use_l1) begin
            ra0 = a; ra1 = b; req0 = 1'b0; req1 = 1'b0;
        end else begin
            req0 = a; req1 = b; ra0 = 1'b0; ra1 = 1'b0;
        end
        e.sel    = s;
        e.mem_en = (s != 2'b00);
        e.busy   = (s != 2'b00);
        e.done0  = d0;
        e.done1  = d1;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        o = use_l1 ? {sel_b, mem_en_b, done0_b, done1_b, busy_b}
                   : {sel, mem_en, done0, done1, busy};
        e = exp_q.pop_front();
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s: observed sel/en/d0/d1/busy=%b required %b", tag, o, e);
        end
    endtask

    // Protocol invariants on both instances, sampled mid-cycle.
    always @(negedge clk) begin
        checks++;
        assert (sel !== 2'b11 && !(done0 && done1) && mem_en === (sel != 2'b00)
                && busy === mem_en) else begin
            failures++;
            $error("FAIL inv_l3: observed sel=%b en=%b d0=%b d1=%b busy=%b required legal combination",
                   sel, mem_en, done0, done1, busy);
        end
        checks++;
        assert (sel_b !== 2'b11 && !(done0_b && done1_b) && mem_en_b === (sel_b != 2'b00)
                && busy_b === mem_en_b) else begin
            failures++;
            $error("FAIL inv_l1: observed sel=%b en=%b d0=%b d1=%b busy=%b required legal combination",
                   sel_b, mem_en_b, done0_b, done1_b, busy_b);
        end
    end

    initial begin
        logic [1:0] s;
        bit         g1;

        // Reset held for two cycles with both requests high.
        cyc(0, 1'b0, 1, 1, 2'b00, 0, 0, "reset_c1");
        cyc(0, 1'b0, 1, 1, 2'b00, 0, 0, "reset_c2");
        cyc(0, 1'b1, 0, 0, 2'b00, 0, 0, "idle_after_reset");

        // Single fetch access.
        cyc(0, 1'b1, 1, 0, 2'b01, 0, 0, "g0_c1");
        cyc(0, 1'b1, 1, 0, 2'b01, 0, 0, "g0_c2");
        cyc(0, 1'b1, 1, 0, 2'b01, 1, 0, "g0_c3_done");
        cyc(0, 1'b1, 1, 0, 2'b00, 0, 0, "g0_turnaround");
        cyc(0, 1'b1, 0, 0, 2'b00, 0, 0, "g0_idle");

        // Continuous contention for 12 cycles from a fresh reset.
        cyc(0, 1'b0, 0, 0, 2'b00, 0, 0, "reset_before_contention");
        for (int i = 0; i < 12; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
            g1 = ((i / 4) % 2) == 1;
`else
            g1 = 1'b0;
`endif
            s = ((i % 4) == 3) ? 2'b00 : (g1 ? 2'b10 : 2'b01);
            cyc(0, 1'b1, 1, 1, s, (i % 4 == 2) && !g1, (i % 4 == 2) && g1, "contention");
        end
        cyc(0, 1'b1, 0, 0, 2'b00, 0, 0, "contention_release");

        // req1 arrives mid-GRANT0 and is served after the turnaround.
        cyc(0, 1'b1, 1, 0, 2'b01, 0, 0, "late1_g0_c1");
        cyc(0, 1'b1, 1, 0, 2'b01, 0, 0, "late1_g0_c2");
        cyc(0, 1'b1, 1, 1, 2'b01, 1, 0, "late1_g0_done");
        cyc(0, 1'b1, 1, 1, 2'b00, 0, 0, "late1_turnaround");
        cyc(0, 1'b1, 0, 1, 2'b10, 0, 0, "late1_g1_c1");
        cyc(0, 1'b1, 0, 1, 2'b10, 0, 0, "late1_g1_c2");
        cyc(0, 1'b1, 0, 1, 2'b10, 0, 1, "late1_g1_done");
        cyc(0, 1'b1, 0, 1, 2'b00, 0, 0, "late1_idle");
        cyc(0, 1'b1, 0, 0, 2'b00, 0, 0, "late1_quiet");

        // Reset during cycle 2 of a GRANT1 aborts the access without a done pulse.
        cyc(0, 1'b1, 0, 1, 2'b10, 0, 0, "abort_g1_c1");
        cyc(0, 1'b1, 0, 1, 2'b10, 0, 0, "abort_g1_c2");
        cyc(0, 1'b0, 0, 1, 2'b00, 0, 0, "abort_reset");
        cyc(0, 1'b1, 0, 0, 2'b00, 0, 0, "abort_no_done");

        // Latency-1 instance: single-cycle grants with done in the same cycle.
        cyc(1, 1'b1, 1, 0, 2'b01, 1, 0, "l1_g0");
        cyc(1, 1'b1, 1, 0, 2'b00, 0, 0, "l1_g0_turnaround");
        cyc(1, 1'b1, 0, 1, 2'b10, 0, 1, "l1_g1");
        cyc(1, 1'b1, 0, 1, 2'b00, 0, 0, "l1_g1_turnaround");
        cyc(1, 1'b1, 1, 1, 2'b01, 1, 0, "l1_contend_a");
        cyc(1, 1'b1, 1, 1, 2'b00, 0, 0, "l1_contend_gap");
`ifdef ARB_ROUND_ROBIN_EN
        cyc(1, 1'b1, 1, 1, 2'b10, 0, 1, "l1_contend_b");
`else
        cyc(1, 1'b1, 1, 1, 2'b01, 1, 0, "l1_contend_b");
`endif
        cyc(1, 1'b1, 0, 0, 2'b00, 0, 0, "l1_contend_end");

        // Random request streams on both instances; invariants are checked every cycle.
        for (int i = 0; i < 300; i++) begin
            rst_n = (i % 97) != 50;
            req0  = 1'($urandom_range(0, 1));
            req1  = 1'($urandom_range(0, 1));
            ra0   = 1'($urandom_range(0, 1));
            ra1   = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
